// File: rtl/id_ctrl_pipe_pkg.sv
// Shared RV32I decode constants, control bundle type and small decode helpers.
package id_ctrl_pipe_pkg;

  localparam logic [2:0] INST_R = 3'd0;
  localparam logic [2:0] INST_I = 3'd1;
  localparam logic [2:0] INST_S = 3'd2;
  localparam logic [2:0] INST_B = 3'd3;
  localparam logic [2:0] INST_U = 3'd4;
  localparam logic [2:0] INST_J = 3'd5;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  // 16..23 follow funct3 order: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  localparam logic [4:0] ALU_MUL   = 5'd16;
  localparam logic [4:0] ALU_REMU  = 5'd23;
  localparam logic [4:0] ALU_BEQ   = 5'd24;
  localparam logic [4:0] ALU_BNE   = 5'd25;
  localparam logic [4:0] ALU_BLT   = 5'd26;
  localparam logic [4:0] ALU_BGE   = 5'd27;
  localparam logic [4:0] ALU_BLTU  = 5'd28;
  localparam logic [4:0] ALU_BGEU  = 5'd29;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] inst_type;
    logic [4:0] alu_op;
    logic       rf_we;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_size;
    logic       mem_uns;
    logic       br_op;
    logic       jal_op;
    logic       jalr_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic [4:0] op_alu(input logic [2:0] f3);
    logic [4:0] a;
    case (f3)
      3'd0:    a = ALU_ADD;
      3'd1:    a = ALU_SLL;
      3'd2:    a = ALU_SLT;
      3'd3:    a = ALU_SLTU;
      3'd4:    a = ALU_XOR;
      3'd5:    a = ALU_SRL;
      3'd6:    a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  function automatic logic [4:0] br_alu(input logic [2:0] f3);
    logic [4:0] a;
    case (f3)
      3'd0:    a = ALU_BEQ;
      3'd1:    a = ALU_BNE;
      3'd4:    a = ALU_BLT;
      3'd5:    a = ALU_BGE;
      3'd6:    a = ALU_BLTU;
      default: a = ALU_BGEU;
    endcase
    return a;
  endfunction

  function automatic logic rd_hit(input logic [4:0] r, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic use1, input logic use2);
    return (r != 5'd0) && ((use1 && (r == rs1)) || (use2 && (r == rs2)));
  endfunction

endpackage

// File: rtl/rv32_dec.sv
// Combinational RV32I decoder: instruction word to control bundle plus source-use flags.
// Define CTRL_RV32M_EN to decode the M-extension OP encodings.
module rv32_dec
  import id_ctrl_pipe_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        use_rs1,
  output logic        use_rs2
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    ctrl     = '0;
    ctrl.rs1 = inst[19:15];
    ctrl.rs2 = inst[24:20];
    legal    = 1'b0;
    use_rs1  = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    use_rs2  = opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    case (opc)
      OPC_LUI: begin
        legal = 1'b1; ctrl.inst_type = INST_U; ctrl.alu_op = ALU_PASSB; ctrl.rf_we = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1; ctrl.inst_type = INST_U; ctrl.alu_op = ALU_ADD; ctrl.rf_we = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; ctrl.inst_type = INST_J; ctrl.rf_we = 1'b1; ctrl.jal_op = 1'b1;
      end
      OPC_JALR: begin
        legal = (f3 == 3'd0); ctrl.inst_type = INST_I; ctrl.rf_we = 1'b1; ctrl.jalr_op = 1'b1;
      end
      OPC_BRANCH: begin
        legal = !(f3 inside {3'd2, 3'd3});
        ctrl.inst_type = INST_B; ctrl.alu_op = br_alu(f3); ctrl.br_op = 1'b1;
      end
      OPC_LOAD: begin
        legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        ctrl.inst_type = INST_I; ctrl.rf_we = 1'b1; ctrl.mem_rd = 1'b1;
        ctrl.mem_size = f3[1:0]; ctrl.mem_uns = f3[2];
      end
      OPC_STORE: begin
        legal = (f3 <= 3'd2);
        ctrl.inst_type = INST_S; ctrl.mem_wr = 1'b1; ctrl.mem_size = f3[1:0];
      end
      OPC_OPIMM: begin
        ctrl.inst_type = INST_I; ctrl.rf_we = 1'b1; ctrl.alu_op = op_alu(f3);
        if (f3 == 3'd1) begin
          legal = (f7 == F7_ZERO);
        end else if (f3 == 3'd5) begin
          legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
          if (f7 == F7_ALT) ctrl.alu_op = ALU_SRA;
        end else begin
          legal = 1'b1;
        end
      end
      OPC_OP: begin
        ctrl.inst_type = INST_R; ctrl.rf_we = 1'b1;
        if (f7 == F7_ZERO) begin
          legal = 1'b1; ctrl.alu_op = op_alu(f3);
        end else if (f7 == F7_ALT) begin
          legal = (f3 == 3'd0) || (f3 == 3'd5);
          ctrl.alu_op = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
        end else if (f7 == F7_MULDIV) begin
`ifdef CTRL_RV32M_EN
          legal = 1'b1; ctrl.alu_op = ALU_MUL | {2'b00, f3};
`else
          legal = 1'b0;
`endif
        end
      end
      OPC_FENCE: begin
        legal = 1'b1; ctrl.inst_type = INST_I;
      end
      default: legal = 1'b0;
    endcase
    // Illegal words keep their register indices but carry no side effects
    if (!legal) begin
      ctrl.illegal   = 1'b1;
      ctrl.inst_type = INST_R;
      ctrl.alu_op    = ALU_ADD;
      ctrl.rf_we     = 1'b0;
      ctrl.mem_rd    = 1'b0;
      ctrl.mem_wr    = 1'b0;
      ctrl.mem_size  = 2'd0;
      ctrl.mem_uns   = 1'b0;
      ctrl.br_op     = 1'b0;
      ctrl.jal_op    = 1'b0;
      ctrl.jalr_op   = 1'b0;
    end
    ctrl.rd = ctrl.rf_we ? inst[11:7] : 5'd0;
  end

endmodule

// File: rtl/id_ctrl_pipe.sv
// RV32I decode/control pipeline stage with load-use stall and EX flush.
// Build with CTRL_RV32M_EN defined to accept the M-extension (decoded in rv32_dec).
module id_ctrl_pipe
  import id_ctrl_pipe_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      inst_type,
  output logic [4:0]      alu_op,
  output logic            rf_we,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [1:0]      mem_size,
  output logic            mem_uns,
  output logic            br_op,
  output logic            jal_op,
  output logic            jalr_op,
  output logic            illegal
);

  ctrl_t                     dec_ctrl;
  ctrl_t                     bundle_q;
  logic [XLEN-1:0]           pc_q;
  logic                      valid_q;
  logic                      use_rs1;
  logic                      use_rs2;
  logic                      adv;
  logic                      match;
  logic                      hazard;
  logic                      accept;
  logic [LOAD_LAT-1:0]       pend_v_q;
  logic [LOAD_LAT-1:0][4:0]  pend_rd_q;

  rv32_dec u_dec (
    .inst    (inst),
    .ctrl    (dec_ctrl),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < int'(LOAD_LAT); i++) begin
      if (pend_v_q[i] && rd_hit(pend_rd_q[i], inst[19:15], inst[24:20], use_rs1, use_rs2)) begin
        match = 1'b1;
      end
    end
    if (valid_q && bundle_q.mem_rd && !out_ready &&
        rd_hit(bundle_q.rd, inst[19:15], inst[24:20], use_rs1, use_rs2)) begin
      match = 1'b1;
    end
  end

  assign adv      = !valid_q || out_ready;
  assign hazard   = in_valid && match;
  assign in_ready = flush || (adv && !hazard);
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (adv) begin
      valid_q <= accept;
      if (accept) begin
        bundle_q <= dec_ctrl;
        pc_q     <= pc_in;
      end
    end
  end

  // Loads already handed to EX; flush leaves them alone since they still complete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q  <= '0;
      pend_rd_q <= '0;
    end else if (out_ready) begin
      for (int i = int'(LOAD_LAT) - 1; i > 0; i--) begin
        pend_v_q[i]  <= pend_v_q[i-1];
        pend_rd_q[i] <= pend_rd_q[i-1];
      end
      pend_v_q[0]  <= valid_q && bundle_q.mem_rd && (bundle_q.rd != 5'd0);
      pend_rd_q[0] <= bundle_q.rd;
    end
  end

  assign out_valid = valid_q;
  assign pc_out    = pc_q;
  assign rs1       = bundle_q.rs1;
  assign rs2       = bundle_q.rs2;
  assign rd        = bundle_q.rd;
  assign inst_type = bundle_q.inst_type;
  assign alu_op    = bundle_q.alu_op;
  assign rf_we     = bundle_q.rf_we;
  assign mem_rd    = bundle_q.mem_rd;
  assign mem_wr    = bundle_q.mem_wr;
  assign mem_size  = bundle_q.mem_size;
  assign mem_uns   = bundle_q.mem_uns;
  assign br_op     = bundle_q.br_op;
  assign jal_op    = bundle_q.jal_op;
  assign jalr_op   = bundle_q.jalr_op;
  assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe: decode, load-use stall, backpressure, flush, async reset.
module tb_id_ctrl_pipe;
  import id_ctrl_pipe_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h00028333;  // add x6,x5,x0
  localparam logic [31:0] I_SW   = 32'h0020A223;  // sw x2,4(x1)
  localparam logic [31:0] I_MUL  = 32'h022081B3;  // mul x3,x1,x2

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  inst_type;
  logic [4:0]  alu_op;
  logic        rf_we, mem_rd, mem_wr, mem_uns, br_op, jal_op, jalr_op, illegal;
  logic [1:0]  mem_size;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] vin  [14];
  logic [19:0] vexp [14];

  id_ctrl_pipe #(.XLEN(32), .LOAD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .pc_in     (pc_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc_out    (pc_out),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .inst_type (inst_type),
    .alu_op    (alu_op),
    .rf_we     (rf_we),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_size  (mem_size),
    .mem_uns   (mem_uns),
    .br_op     (br_op),
    .jal_op    (jal_op),
    .jalr_op   (jalr_op),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; returns 1 time unit later.
  task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] pc,
                     input logic fl, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    inst      = i;
    pc_in     = pc;
    flush     = fl;
    out_ready = ordy;
    #1;
  endtask

  function automatic logic [19:0] pk(input logic ill, input logic we, input logic mrd,
                                     input logic mwr, input logic [1:0] sz, input logic uns,
                                     input logic br, input logic jl, input logic jr,
                                     input logic [4:0] alu, input logic [4:0] rde);
    return {ill, we, mrd, mwr, sz, uns, br, jl, jr, alu, rde};
  endfunction

  initial begin
    vin[0]  = 32'h00109093; vexp[0]  = pk(0, 1, 0, 0, 2'd0, 0, 0, 0, 0, ALU_SLL, 5'd1);
    vin[1]  = 32'h40109093; vexp[1]  = pk(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, ALU_ADD, 5'd0);
    vin[2]  = 32'h4010D093; vexp[2]  = pk(0, 1, 0, 0, 2'd0, 0, 0, 0, 0, ALU_SRA, 5'd1);
    vin[3]  = 32'h0000C283; vexp[3]  = pk(0, 1, 1, 0, 2'd0, 1, 0, 0, 0, ALU_ADD, 5'd5);
    vin[4]  = 32'h0000000F; vexp[4]  = pk(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, ALU_ADD, 5'd0);
    vin[5]  = 32'h0000007F; vexp[5]  = pk(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, ALU_ADD, 5'd0);
    vin[6]  = 32'h00208463; vexp[6]  = pk(0, 0, 0, 0, 2'd0, 0, 1, 0, 0, ALU_BEQ, 5'd0);
    vin[7]  = 32'h000000EF; vexp[7]  = pk(0, 1, 0, 0, 2'd0, 0, 0, 1, 0, ALU_ADD, 5'd1);
    vin[8]  = 32'h00008067; vexp[8]  = pk(0, 1, 0, 0, 2'd0, 0, 0, 0, 1, ALU_ADD, 5'd0);
    vin[9]  = 32'h123452B7; vexp[9]  = pk(0, 1, 0, 0, 2'd0, 0, 0, 0, 0, ALU_PASSB, 5'd5);
    vin[10] = 32'h402081B3; vexp[10] = pk(0, 1, 0, 0, 2'd0, 0, 0, 0, 0, ALU_SUB, 5'd3);
    vin[11] = 32'h0010B193; vexp[11] = pk(0, 1, 0, 0, 2'd0, 0, 0, 0, 0, ALU_SLTU, 5'd3);
    vin[12] = 32'h0020F463; vexp[12] = pk(0, 0, 0, 0, 2'd0, 0, 1, 0, 0, ALU_BGEU, 5'd0);
    vin[13] = 32'h0000B283; vexp[13] = pk(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, ALU_ADD, 5'd0);

    rst = 1'b1; in_valid = 1'b0; inst = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_pc_out", pc_out, 32'd0);
    check_eq("rst_bundle", {12'd0, illegal, rf_we, mem_rd, mem_wr, mem_size, mem_uns, br_op,
                            jal_op, jalr_op, alu_op, rd}, 32'd0);
    rst = 1'b0;

    // add x3,x1,x2 with one-cycle latency
    cyc(1, I_ADD, 32'h100, 0, 1);
    check_eq("add_in_ready", {31'd0, in_ready}, 32'd1);
    cyc(0, 32'h0, 32'h0, 0, 1);
    check_eq("add_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("add_alu", {27'd0, alu_op}, {27'd0, ALU_ADD});
    check_eq("add_rd", {27'd0, rd}, 32'd3);
    check_eq("add_we_ill", {30'd0, rf_we, illegal}, 32'b10);
    check_eq("add_type", {29'd0, inst_type}, {29'd0, INST_R});
    check_eq("add_pc", pc_out, 32'h100);

    // lw x5 issues; dependent add arrives while the load sits in the tracker
    cyc(1, I_LW, 32'h104, 0, 1);
    cyc(0, 32'h0, 32'h0, 0, 1);
    check_eq("lw_out", {29'd0, out_valid, mem_rd, rf_we}, 32'b111);
    check_eq("lw_rd", {27'd0, rd}, 32'd5);
    cyc(1, I_ADD6, 32'h108, 0, 1);
    check_eq("lu_stall_ready", {31'd0, in_ready}, 32'd0);
    cyc(1, I_ADD6, 32'h108, 0, 1);
    check_eq("lu_bubble", {31'd0, out_valid}, 32'd0);
    check_eq("lu_release_ready", {31'd0, in_ready}, 32'd1);
    cyc(1, I_SW, 32'h10C, 0, 1);
    check_eq("lu_add_issue", {26'd0, out_valid, rd}, {26'd0, 1'b1, 5'd6});
    check_eq("lu_add_pc", pc_out, 32'h108);

    // Backpressure while holding sw
    cyc(1, I_ADD, 32'h110, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("bp_valid%0d", k), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("bp_store%0d", k), {27'd0, mem_wr, mem_size, rf_we, mem_rd},
               {27'd0, 1'b1, 2'd2, 1'b0, 1'b0});
      check_eq($sformatf("bp_rd%0d", k), {27'd0, rd}, 32'd0);
      check_eq($sformatf("bp_pc%0d", k), pc_out, 32'h10C);
      check_eq($sformatf("bp_in_ready%0d", k), {31'd0, in_ready}, 32'd0);
      if (k < 2) cyc(1, I_ADD, 32'h110, 0, 0);
    end
    cyc(1, I_ADD, 32'h110, 0, 1);
    check_eq("bp_release", {31'd0, in_ready}, 32'd1);

    // Flush while a valid bundle is held; tracker keeps the older load
    cyc(1, I_LW, 32'h114, 0, 1);
    cyc(1, I_ADD, 32'h118, 0, 1);
    cyc(1, I_SW, 32'h11C, 1, 0);
    check_eq("fl_held_valid", {31'd0, out_valid}, 32'd1);
    check_eq("fl_in_ready", {31'd0, in_ready}, 32'd1);
    cyc(1, I_ADD6, 32'h120, 0, 0);
    check_eq("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("fl_tracker_kept", {31'd0, in_ready}, 32'd0);
    cyc(0, 32'h0, 32'h0, 0, 1);

    // M-extension encoding
    cyc(1, I_MUL, 32'h124, 0, 1);
    cyc(0, 32'h0, 32'h0, 0, 1);
`ifdef CTRL_RV32M_EN
    check_eq("mul_decode", {25'd0, out_valid, illegal, rf_we, alu_op[3:0]},
             {25'd0, 1'b1, 1'b0, 1'b1, ALU_MUL[3:0]});
    check_eq("mul_alu", {27'd0, alu_op}, {27'd0, ALU_MUL});
`else
    check_eq("mul_decode", {28'd0, out_valid, illegal, rf_we, mem_wr}, {28'd0, 4'b1100});
    check_eq("mul_rd", {27'd0, rd}, 32'd0);
`endif

    // Decode table
    for (int k = 0; k < 14; k++) begin
      cyc(1, vin[k], 32'h300 + 32'(k * 4), 0, 1);
      cyc(0, 32'h0, 32'h0, 0, 1);
      check_eq($sformatf("dec%0d", k),
               {12'd0, illegal, rf_we, mem_rd, mem_wr, mem_size, mem_uns, br_op, jal_op,
                jalr_op, alu_op, rd}, {12'd0, vexp[k]});
    end

    // Async reset during a stall, with a load in the tracker
    cyc(1, I_LW, 32'h200, 0, 1);
    cyc(1, I_SW, 32'h204, 0, 1);
    cyc(1, I_ADD6, 32'h208, 0, 0);
    check_eq("rs_pre_valid", {31'd0, out_valid}, 32'd1);
    check_eq("rs_pre_ready", {31'd0, in_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check_eq("rs_async_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rs_async_bundle", {29'd0, mem_wr, mem_rd, rf_we}, 32'd0);
    check_eq("rs_async_pc", pc_out, 32'd0);
    check_eq("rs_tracker_clr", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, I_ADD6, 32'h20C, 0, 1);
    check_eq("rs_after_ready", {31'd0, in_ready}, 32'd1);
    cyc(0, 32'h0, 32'h0, 0, 1);
    check_eq("rs_after_issue", {26'd0, out_valid, rd}, {26'd0, 1'b1, 5'd6});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
